// File: rtl/ddr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ddr_pkg: lane indices, play-state enum and hit score weights.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package ddr_pkg;
  localparam int UP    = 3;
  localparam int DOWN  = 2;
  localparam int LEFT  = 1;
  localparam int RIGHT = 0;

  localparam int PERFECT = 3;
  localparam int GOOD    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/arrow_lane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arrow_lane: one lane shift register with hit-zone judge and miss. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module arrow_lane #(
  parameter int ROWS     = 16,
  parameter int HIT_ROWS = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            press,
  input  logic            scroll,
  input  logic            insert,
  output logic [ROWS-1:0] rows,
  output logic            hit,
  output logic            perfect,
  output logic            miss,
  output logic            empty_next
);
  logic [ROWS-1:0] w_lowest;
  logic [ROWS-1:0] w_cleared;
  logic [ROWS-1:0] w_shifted;
  logic [ROWS-1:0] w_next;

  // Ascending scan leaves only the highest occupied row of the zone selected.
  always_comb begin
    w_lowest = '0;
    for (int r = ROWS - HIT_ROWS; r < ROWS; r++) begin
      if (rows[r]) begin
        w_lowest    = '0;
        w_lowest[r] = 1'b1;
      end
    end
  end

  assign hit        = press & (|w_lowest);
  assign perfect    = hit & rows[ROWS-1];
  assign w_cleared  = hit ? (rows & ~w_lowest) : rows;
  assign miss       = scroll & w_cleared[ROWS-1];
  assign w_shifted  = scroll ? (w_cleared << 1) : w_cleared;
  assign w_next     = clear ? '0 : (w_shifted | ROWS'(insert));
  assign empty_next = ~(|w_next);

  always_ff @(posedge clock) begin
    if (reset) begin
      rows <= '0;
    end else begin
      rows <= w_next;
    end
  end
endmodule
`default_nettype wire

// File: rtl/arrow_lane_scroller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arrow_lane_scroller: four scrolling arrow lanes, judge and score. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module arrow_lane_scroller #(
  parameter int ROWS     = 16,
  parameter int HIT_ROWS = 2,
  parameter int SCORE_W  = 16,
  parameter int COMBO_W  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                game_active,
  input  logic [3:0]          pattern_in,
  input  logic                pattern_valid,
  input  logic                scroll_tick,
  input  logic [3:0]          key_in,
  output logic [4*ROWS-1:0]   lane_rows,
  output logic [3:0]          hit_lanes,
  output logic [3:0]          miss_lanes,
  output logic [SCORE_W-1:0]  score,
  output logic [COMBO_W-1:0]  combo,
  output logic [COMBO_W-1:0]  max_combo,
  output logic                busy
);
  import ddr_pkg::*;

  state_t r_state;
  state_t w_state_next;

  logic       r_pv_q;
  logic [3:0] r_key_q;

  logic       w_clear, w_fresh, w_run, w_can_insert;
  logic       w_insert, w_scroll, w_board_empty;
  logic [3:0] w_press, w_hit, w_perfect, w_miss, w_empty_lane;

  logic [3:0]           w_gain;
  logic [2:0]           w_hits_cnt;
  logic [SCORE_W:0]     w_score_sum;
  logic [SCORE_W-1:0]   w_score_new;
  logic [COMBO_W:0]     w_combo_sum;
  logic [COMBO_W-1:0]   w_combo_new;
  logic [COMBO_W-1:0]   w_max_new;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (game_active) w_state_next = PLAY;
      PLAY:    if (!game_active) w_state_next = DRAIN;
      DRAIN: begin
        if (game_active)        w_state_next = PLAY;
        else if (w_board_empty) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Returning to PLAY from DRAIN is a fresh game, so it clears like a start.
  always_comb begin
    w_clear      = 1'b1;
    w_fresh      = 1'b0;
    w_run        = 1'b0;
    w_can_insert = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        w_fresh = game_active;
      end
      PLAY: begin
        w_clear      = 1'b0;
        w_run        = 1'b1;
        w_can_insert = 1'b1;
        busy         = 1'b1;
      end
      DRAIN: begin
        w_clear = game_active;
        w_fresh = game_active;
        w_run   = ~game_active;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_insert = w_can_insert & pattern_valid & ~r_pv_q;
  assign w_press  = w_run ? (key_in & ~r_key_q) : 4'b0000;
  assign w_scroll = w_run & scroll_tick;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    arrow_lane #(
      .ROWS     (ROWS),
      .HIT_ROWS (HIT_ROWS)
    ) u_lane (
      .clock      (clock),
      .reset      (reset),
      .clear      (w_clear),
      .press      (w_press[l]),
      .scroll     (w_scroll),
      .insert     (w_insert & pattern_in[l]),
      .rows       (lane_rows[l*ROWS +: ROWS]),
      .hit        (w_hit[l]),
      .perfect    (w_perfect[l]),
      .miss       (w_miss[l]),
      .empty_next (w_empty_lane[l])
    );
  end

  assign w_board_empty = &w_empty_lane;

  always_comb begin
    w_gain     = '0;
    w_hits_cnt = '0;
    for (int l = 0; l < 4; l++) begin
      if (w_hit[l]) begin
        w_gain     = w_gain + (w_perfect[l] ? 4'(PERFECT) : 4'(GOOD));
        w_hits_cnt = w_hits_cnt + 3'd1;
      end
    end
  end

  assign w_score_sum = {1'b0, score} + (SCORE_W+1)'(w_gain);
  assign w_score_new = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
  assign w_combo_sum = {1'b0, combo} + (COMBO_W+1)'(w_hits_cnt);
  // A miss anywhere in the cycle breaks the streak even if other lanes hit.
  assign w_combo_new = (|w_miss) ? '0 :
                       (w_combo_sum[COMBO_W] ? '1 : w_combo_sum[COMBO_W-1:0]);
  assign w_max_new   = (w_combo_new > max_combo) ? w_combo_new : max_combo;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pv_q     <= 1'b0;
      r_key_q    <= '0;
      hit_lanes  <= '0;
      miss_lanes <= '0;
      score      <= '0;
      combo      <= '0;
      max_combo  <= '0;
    end else begin
      r_pv_q     <= pattern_valid;
      r_key_q    <= key_in;
      hit_lanes  <= w_hit;
      miss_lanes <= w_miss;
      if (w_fresh) begin
        score     <= '0;
        combo     <= '0;
        max_combo <= '0;
      end else if (w_run) begin
        score     <= w_score_new;
        combo     <= w_combo_new;
        max_combo <= w_max_new;
      end
    end
  end
endmodule
`default_nettype wire

// File: doc/arrow_lane_scroller.md
# arrow_lane_scroller

Downstream consumer of the arrow pattern generator. Takes each new UDLR pattern, inserts it at the top row of four lane shift registers and scrolls the arrows toward the hit zone on every scroll tick. It judges player key presses against arrows in the hit zone and keeps score, combo and max combo. Its lane occupancy output drives the VGA arrow renderer; its hit and miss pulses drive the feedback and sound logic.

## Interface
- ROWS, 16: rows per lane; row 0 is the top, row ROWS-1 is the bottom.
- HIT_ROWS, 2: number of bottom rows forming the hit zone (1..ROWS).
- SCORE_W, 16: score counter width.
- COMBO_W, 8: combo and max-combo counter width.

- clock  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- game_active  in  1  play-state level from the game controller.
- pattern_in  in  4  arrow pattern, UDLR order (bit3 = up, bit0 = right).
- pattern_valid  in  1  level; high for one or more cycles per pattern.
- scroll_tick  in  1  one-cycle pulse; advances all arrows one row.
- key_in  in  4  player buttons, UDLR, synchronised and debounced, level.
- lane_rows  out  4*ROWS  occupancy; bit [lane*ROWS + row], lane 3 = up.
- hit_lanes  out  4  one-cycle mask of lanes hit this cycle.
- miss_lanes  out  4  one-cycle mask of lanes missed this cycle.
- score  out  SCORE_W  accumulated score, saturating.
- combo  out  COMBO_W  current consecutive hits, saturating.
- max_combo  out  COMBO_W  highest combo this game.
- busy  out  1  high in PLAY and DRAIN.

## Operation
- FSM states: IDLE, PLAY, DRAIN. All outputs and state are registered.
- IDLE to PLAY on game_active high. That transition clears the board, score, combo and max_combo.
- PLAY to DRAIN on game_active low.
- DRAIN to IDLE when the board is all-zero after the update.
- DRAIN to PLAY if game_active returns high; this is a fresh-game clear.
- Insert:
  - Only in PLAY, on the rising edge of pattern_valid (compared against its registered copy).
  - Row 0 of each lane is ORed with pattern_in.
  - A held pattern_valid inserts once.
- Key press:
  - Rising edge of key_in[l], in PLAY or DRAIN only.
  - If lane l has any arrow in rows ROWS-HIT_ROWS..ROWS-1, the lowest such arrow (highest row) is cleared and hit_lanes[l] is set.
  - A stray press with no arrow in the zone is ignored: no score change, no combo change.
- Scroll, in PLAY or DRAIN when scroll_tick is high:
  - Every lane shifts row r to row r+1.
  - An arrow leaving row ROWS-1 that was not hit this cycle sets miss_lanes for its lane.
- Per-cycle update order:
  1. Compute hits on the current board.
  2. Clear the hit arrows.
  3. Shift, detecting misses.
  4. Insert at row 0.
- Insert and scroll in the same cycle: the pattern lands in row 0 after the shift.
- Scoring:
  - A hit in row ROWS-1 scores 3 (perfect); any other hit-zone row scores 1.
  - The sum over all lanes hit this cycle is added to score, saturating at all-ones.
- Combo:
  - combo adds popcount(hit_lanes), saturating.
  - Any miss in the cycle forces combo to 0, overriding hits in the same cycle.
  - max_combo is updated to max(max_combo, new combo) in the same cycle.
- In IDLE: inputs are ignored; the board is held at zero; score and max_combo hold the last game's values.

## Timing
- Reset: state IDLE; the following are all zero:
  - lane_rows, hit_lanes, miss_lanes
  - score, combo, max_combo, busy
  - the edge-detect registers for pattern_valid and key_in
- Reset mid-game takes effect at the next edge and overrides every other event.
- Insert latency: pattern_valid sampled high (registered copy low) at edge n appears in lane_rows after edge n.
- Key latency: key_in sampled high (registered copy low) at edge n produces hit_lanes, score and combo after edge n. hit_lanes is high for exactly one cycle.
- Miss latency: miss_lanes is valid after the same edge as the scroll_tick that caused it.
- busy follows the state register.

## Structure
- Shared package ddr_pkg holds:
  - UDLR bit-index constants (UP=3, DOWN=2, LEFT=1, RIGHT=0)
  - the FSM state enum
  - the score weights (PERFECT=3, GOOD=1)
- Sub-module arrow_lane (parameters ROWS, HIT_ROWS), instantiated four times. Each instance holds:
  - one lane's shift register
  - the lowest-in-zone hit search and clear
  - miss detection
  - per-lane outputs: hit, perfect, miss
- The top level holds the FSM, the edge detectors, scoring, the combo counters and lane_rows packing.

## Test plan
- Reset, then game_active=1, pattern_valid held high 3 cycles with pattern_in=4'b1010 -> exactly one insert; row 0 set in lanes up and left only.
- Insert 4'b0001, then ROWS-1 scroll ticks, then press key_in[0] -> hit_lanes=4'b0001, score=3, combo=1.
- Insert 4'b0100, then ROWS scroll ticks with no key -> miss_lanes=4'b0100 on the last tick; combo=0; board empty.
- Build combo=5; press key_in[2] with lane down hit-zone empty -> no hit, score and combo unchanged. Then let a down arrow fall out -> combo=0, max_combo=5.
- Two arrows in right lane at rows ROWS-2 and ROWS-1; one press -> only row ROWS-1 cleared, score +3. Second press -> score +1 (provided no scroll intervened).
- Drop game_active with arrows on board -> busy stays 1 while DRAIN scrolls; IDLE when empty; pattern_valid edges during DRAIN ignored. Assert reset mid-DRAIN -> all outputs zero next cycle.
